// File: rtl/jarvis_pkg.sv
// Shared types for the writeback scheduler: register address width,
// write-port grant encoding and long-latency buffer states.
package jarvis_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_PIPE,
        GNT_BUF
    } grant_t;

    typedef enum logic [1:0] {
        EMPTY,
        HELD,
        FORCE
    } buf_state_t;

endpackage

// File: rtl/wb_scheduler_if.sv
// Bundle of the scheduler's issue, decode, pipeline, long-latency and
// register-file signals. The scheduler uses the slave view; whatever
// drives it (pipeline or bench) uses the master view.
interface wb_scheduler_if
    import jarvis_pkg::*;
#(
    parameter int XLEN = 32
);
    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic                  issue_ready;

    logic [REG_ADDR_W-1:0] dec_rs1;
    logic [REG_ADDR_W-1:0] dec_rs2;
    logic [REG_ADDR_W-1:0] dec_rd;
    logic                  hazard_stall;

    logic                  pipe_valid;
    logic [REG_ADDR_W-1:0] pipe_rd;
    logic [XLEN-1:0]       pipe_data;
    logic                  pipe_stall;

    logic                  lu_valid;
    logic [REG_ADDR_W-1:0] lu_rd;
    logic [XLEN-1:0]       lu_data;
    logic                  lu_ready;

    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_rd;
    logic [XLEN-1:0]       rf_data;

    modport slave (
        input  issue_valid, issue_rd,
        output issue_ready,
        input  dec_rs1, dec_rs2, dec_rd,
        output hazard_stall,
        input  pipe_valid, pipe_rd, pipe_data,
        output pipe_stall,
        input  lu_valid, lu_rd, lu_data,
        output lu_ready,
        output rf_we, rf_rd, rf_data
    );

    modport master (
        output issue_valid, issue_rd,
        input  issue_ready,
        output dec_rs1, dec_rs2, dec_rd,
        input  hazard_stall,
        output pipe_valid, pipe_rd, pipe_data,
        input  pipe_stall,
        output lu_valid, lu_rd, lu_data,
        input  lu_ready,
        input  rf_we, rf_rd, rf_data
    );

endinterface

// File: rtl/wb_scheduler_scoreboard.sv
// Per-register pending scoreboard for long-latency destinations.
// Lookups are combinational on the current (pre-update) vector; x0 is
// never reported pending.
module wb_scheduler_scoreboard
    import jarvis_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_rd,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  hazard,
    output logic                  issue_busy
);

    logic [NREG-1:0] pending;

    function automatic logic lookup(input logic [NREG-1:0] vec,
                                    input logic [REG_ADDR_W-1:0] idx);
        return (idx != '0) && vec[idx];
    endfunction

    // Clear on buffer drain, set on accepted issue; the issuer never targets
    // a pending register, so the two never hit the same bit in one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            if (clr_en) pending[clr_rd] <= 1'b0;
            if (set_en) pending[set_rd] <= 1'b1;
        end
    end

    assign hazard     = lookup(pending, rs1) || lookup(pending, rs2) || lookup(pending, rd);
    assign issue_busy = lookup(pending, issue_rd);

endmodule

// File: rtl/wb_scheduler.sv
// Register-file write-port arbiter between the in-order writeback result
// and a single buffered long-latency result. The pipeline normally wins;
// after STARVE_MAX consecutive losses the buffer forces a slot and the
// pipeline is stalled for that one cycle.
module wb_scheduler
    import jarvis_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    wb_scheduler_if.slave  bus
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    buf_state_t            buf_state;
    logic [CNT_W-1:0]      starve_cnt;
    logic [REG_ADDR_W-1:0] buf_rd;
    logic [XLEN-1:0]       buf_data;

    grant_t                grant;
    logic                  buf_valid;
    logic                  buf_load;
    logic                  buf_drain;
    logic                  pipe_req;
    logic                  stall;
    logic                  issue_busy;
    logic                  hazard;
    logic                  sb_set;
    logic                  sb_clr;

    // A pipeline write to x0 is swallowed without using the port.
    assign pipe_req  = bus.pipe_valid && (bus.pipe_rd != '0);
    assign buf_valid = (buf_state != EMPTY);
    assign buf_load  = bus.lu_valid && !buf_valid;

    // Grant selection from buffer state and the pipeline request.
    always_comb begin
        grant     = GNT_NONE;
        buf_drain = 1'b0;
        stall     = 1'b0;
        case (buf_state)
            EMPTY: begin
                if (pipe_req) grant = GNT_PIPE;
            end
            HELD: begin
                if (pipe_req) begin
                    grant = GNT_PIPE;
                end else begin
                    buf_drain = 1'b1;
                    grant     = (buf_rd != '0) ? GNT_BUF : GNT_NONE;
                end
            end
            FORCE: begin
                buf_drain = 1'b1;
                grant     = (buf_rd != '0) ? GNT_BUF : GNT_NONE;
                stall     = pipe_req;
            end
            default: begin
                grant = GNT_NONE;
            end
        endcase
    end

    // Buffer-state FSM and starvation counter; a drain always returns to
    // EMPTY with the counter cleared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_state  <= EMPTY;
            starve_cnt <= '0;
        end else begin
            case (buf_state)
                EMPTY: begin
                    if (buf_load) begin
                        buf_state  <= HELD;
                        starve_cnt <= '0;
                    end
                end
                HELD: begin
                    if (pipe_req) begin
                        starve_cnt <= starve_cnt + CNT_W'(1);
                        if (starve_cnt == CNT_W'(STARVE_MAX - 1)) buf_state <= FORCE;
                    end else begin
                        buf_state  <= EMPTY;
                        starve_cnt <= '0;
                    end
                end
                FORCE: begin
                    buf_state  <= EMPTY;
                    starve_cnt <= '0;
                end
                default: begin
                    buf_state  <= EMPTY;
                    starve_cnt <= '0;
                end
            endcase
        end
    end

    // Buffer payload; only meaningful while buf_state != EMPTY, so no reset.
    always_ff @(posedge clk) begin
        if (buf_load) begin
            buf_rd   <= bus.lu_rd;
            buf_data <= bus.lu_data;
        end
    end

    assign sb_set = bus.issue_valid && !issue_busy && (bus.issue_rd != '0);
    assign sb_clr = buf_drain && (buf_rd != '0);

    wb_scheduler_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en     (sb_set),
        .set_rd     (bus.issue_rd),
        .clr_en     (sb_clr),
        .clr_rd     (buf_rd),
        .rs1        (bus.dec_rs1),
        .rs2        (bus.dec_rs2),
        .rd         (bus.dec_rd),
        .issue_rd   (bus.issue_rd),
        .hazard     (hazard),
        .issue_busy (issue_busy)
    );

    assign bus.issue_ready  = !issue_busy;
    assign bus.hazard_stall = hazard;
    assign bus.pipe_stall   = stall;
    assign bus.lu_ready     = !buf_valid;
    assign bus.rf_we        = (grant != GNT_NONE);
    assign bus.rf_rd        = (grant == GNT_BUF) ? buf_rd   : bus.pipe_rd;
    assign bus.rf_data      = (grant == GNT_BUF) ? buf_data : bus.pipe_data;

endmodule

// File: tb/tb_wb_scheduler.sv
// Bench for wb_scheduler: expected register-file writes are queued with
// the cycle they must appear in; a negedge monitor pops and compares them.
module tb_wb_scheduler;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];

    wb_scheduler_if #(.XLEN(32)) bus ();

    wb_scheduler #(
        .XLEN       (32),
        .NREG       (32),
        .STARVE_MAX (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle index, advanced at every rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Write-port monitor: every rf_we must match the head of the queue.
    always @(negedge clk) begin
        wr_t e;
        if (bus.rf_we === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rf_write_unexpected: cycle %0d rd=%0d data=%h, no write expected",
                         cyc, bus.rf_rd, bus.rf_data);
            end else begin
                e = exp_q.pop_front();
                if (cyc !== e.cyc || bus.rf_rd !== e.rd || bus.rf_data !== e.data) begin
                    n_fail++;
                    $display("FAIL rf_write: got cycle %0d rd=%0d data=%h, expected cycle %0d rd=%0d data=%h",
                             cyc, bus.rf_rd, bus.rf_data, e.cyc, e.rd, e.data);
                end
            end
        end
    end

    // Safety bound on total run time.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.dec_rs1     = '0;
        bus.dec_rs2     = '0;
        bus.dec_rd      = '0;
        bus.pipe_valid  = 1'b0;
        bus.pipe_rd     = '0;
        bus.pipe_data   = '0;
        bus.lu_valid    = 1'b0;
        bus.lu_rd       = '0;
        bus.lu_data     = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        bus.dec_rs1  = 5'd5;
        bus.issue_rd = 5'd5;
        step();
        step();
        @(negedge clk);
        n_checks++;
        if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %b expected 0", bus.rf_we); end
        n_checks++;
        if (bus.pipe_stall !== 1'b0) begin n_fail++; $display("FAIL reset_pipe_stall: got %b expected 0", bus.pipe_stall); end
        n_checks++;
        if (bus.hazard_stall !== 1'b0) begin n_fail++; $display("FAIL reset_hazard: got %b expected 0", bus.hazard_stall); end
        n_checks++;
        if (bus.lu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_lu_ready: got %b expected 1", bus.lu_ready); end
        n_checks++;
        if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready: got %b expected 1", bus.issue_ready); end
        rst_n = 1'b1;
        step();
        idle();
    endtask

    task automatic test_issue_drain();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd5;
        @(negedge clk);
        n_checks++;
        if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL drain_issue_ready: got %b expected 1", bus.issue_ready); end
        step();
        bus.issue_valid = 1'b0;
        bus.dec_rs1     = 5'd5;
        bus.lu_valid    = 1'b1;
        bus.lu_rd       = 5'd5;
        bus.lu_data     = 32'hDEADBEEF;
        exp_q.push_back('{cyc + 1, 5'd5, 32'hDEADBEEF});
        @(negedge clk);
        n_checks++;
        if (bus.hazard_stall !== 1'b1) begin n_fail++; $display("FAIL drain_hazard_set: got %b expected 1", bus.hazard_stall); end
        n_checks++;
        if (bus.lu_ready !== 1'b1) begin n_fail++; $display("FAIL drain_lu_ready_empty: got %b expected 1", bus.lu_ready); end
        step();
        bus.lu_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.lu_ready !== 1'b0) begin n_fail++; $display("FAIL drain_lu_ready_held: got %b expected 0", bus.lu_ready); end
        n_checks++;
        if (bus.hazard_stall !== 1'b1) begin n_fail++; $display("FAIL drain_hazard_during: got %b expected 1", bus.hazard_stall); end
        step();
        @(negedge clk);
        n_checks++;
        if (bus.hazard_stall !== 1'b0) begin n_fail++; $display("FAIL drain_hazard_clear: got %b expected 0", bus.hazard_stall); end
        n_checks++;
        if (bus.lu_ready !== 1'b1) begin n_fail++; $display("FAIL drain_lu_ready_after: got %b expected 1", bus.lu_ready); end
        step();
        idle();
    endtask

    task automatic test_starvation();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd9;
        step();
        bus.issue_valid = 1'b0;
        bus.lu_valid    = 1'b1;
        bus.lu_rd       = 5'd9;
        bus.lu_data     = 32'h12345678;
        bus.dec_rs2     = 5'd9;
        step();
        bus.lu_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.pipe_valid = 1'b1;
            if (i < 5) begin
                bus.pipe_rd   = 5'(i + 1);
                bus.pipe_data = 32'hA000_0000 + 32'(i);
            end
            if (i < 4)  exp_q.push_back('{cyc, bus.pipe_rd, bus.pipe_data});
            if (i == 4) exp_q.push_back('{cyc, 5'd9, 32'h12345678});
            if (i == 5) exp_q.push_back('{cyc, 5'd5, 32'hA000_0004});
            @(negedge clk);
            n_checks++;
            if (bus.pipe_stall !== 1'(i == 4)) begin
                n_fail++;
                $display("FAIL starve_pipe_stall[%0d]: got %b expected %b", i, bus.pipe_stall, 1'(i == 4));
            end
            n_checks++;
            if (bus.hazard_stall !== 1'(i < 5)) begin
                n_fail++;
                $display("FAIL starve_hazard[%0d]: got %b expected %b", i, bus.hazard_stall, 1'(i < 5));
            end
            step();
        end
        idle();
    endtask

    task automatic test_issue_blocked();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd7;
        @(negedge clk);
        n_checks++;
        if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL blocked_first_issue: got %b expected 1", bus.issue_ready); end
        step();
        bus.lu_valid = 1'b1;
        bus.lu_rd    = 5'd7;
        bus.lu_data  = 32'h0000_0077;
        exp_q.push_back('{cyc + 1, 5'd7, 32'h0000_0077});
        @(negedge clk);
        n_checks++;
        if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL blocked_reissue: got %b expected 0", bus.issue_ready); end
        step();
        bus.lu_valid = 1'b0;
        bus.issue_rd = 5'd0;
        bus.dec_rd   = 5'd7;
        @(negedge clk);
        n_checks++;
        if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL blocked_issue_x0: got %b expected 1", bus.issue_ready); end
        n_checks++;
        if (bus.hazard_stall !== 1'b1) begin n_fail++; $display("FAIL blocked_hazard_rd: got %b expected 1", bus.hazard_stall); end
        step();
        bus.issue_valid = 1'b0;
        bus.issue_rd    = 5'd7;
        @(negedge clk);
        n_checks++;
        if (bus.hazard_stall !== 1'b0) begin n_fail++; $display("FAIL blocked_hazard_clear: got %b expected 0", bus.hazard_stall); end
        n_checks++;
        if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL blocked_ready_after: got %b expected 1", bus.issue_ready); end
        step();
        idle();
    endtask

    task automatic test_zero_rd();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd11;
        step();
        bus.issue_valid = 1'b0;
        bus.lu_valid    = 1'b1;
        bus.lu_rd       = 5'd11;
        bus.lu_data     = 32'h0000_00BB;
        bus.pipe_valid  = 1'b1;
        bus.pipe_rd     = 5'd2;
        bus.pipe_data   = 32'h0000_00C2;
        exp_q.push_back('{cyc, 5'd2, 32'h0000_00C2});
        @(negedge clk);
        n_checks++;
        if (bus.pipe_stall !== 1'b0) begin n_fail++; $display("FAIL zero_stall_empty: got %b expected 0", bus.pipe_stall); end
        step();
        bus.lu_valid  = 1'b0;
        bus.pipe_rd   = 5'd3;
        bus.pipe_data = 32'h0000_00C3;
        exp_q.push_back('{cyc, 5'd3, 32'h0000_00C3});
        @(negedge clk);
        n_checks++;
        if (bus.pipe_stall !== 1'b0) begin n_fail++; $display("FAIL zero_stall_held: got %b expected 0", bus.pipe_stall); end
        step();
        bus.pipe_rd   = 5'd0;
        bus.pipe_data = 32'hDEAD_0000;
        exp_q.push_back('{cyc, 5'd11, 32'h0000_00BB});
        @(negedge clk);
        n_checks++;
        if (bus.pipe_stall !== 1'b0) begin n_fail++; $display("FAIL zero_stall_x0: got %b expected 0", bus.pipe_stall); end
        n_checks++;
        if (bus.lu_ready !== 1'b0) begin n_fail++; $display("FAIL zero_lu_ready_drain: got %b expected 0", bus.lu_ready); end
        step();
        bus.pipe_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.lu_ready !== 1'b1) begin n_fail++; $display("FAIL zero_lu_ready_after: got %b expected 1", bus.lu_ready); end
        step();
        idle();
    endtask

    task automatic test_back_to_back();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd13;
        step();
        bus.issue_rd = 5'd14;
        step();
        bus.issue_valid = 1'b0;
        bus.lu_valid    = 1'b1;
        bus.lu_rd       = 5'd13;
        bus.lu_data     = 32'h0000_0D13;
        exp_q.push_back('{cyc + 1, 5'd13, 32'h0000_0D13});
        @(negedge clk);
        n_checks++;
        if (bus.lu_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_first_ready: got %b expected 1", bus.lu_ready); end
        step();
        bus.lu_rd   = 5'd14;
        bus.lu_data = 32'h0000_0D14;
        @(negedge clk);
        n_checks++;
        if (bus.lu_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_drain_ready: got %b expected 0", bus.lu_ready); end
        step();
        exp_q.push_back('{cyc + 1, 5'd14, 32'h0000_0D14});
        @(negedge clk);
        n_checks++;
        if (bus.lu_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_second_ready: got %b expected 1", bus.lu_ready); end
        step();
        bus.lu_valid = 1'b0;
        bus.dec_rs1  = 5'd14;
        @(negedge clk);
        n_checks++;
        if (bus.hazard_stall !== 1'b1) begin n_fail++; $display("FAIL b2b_hazard_drain: got %b expected 1", bus.hazard_stall); end
        step();
        @(negedge clk);
        n_checks++;
        if (bus.hazard_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_hazard_clear: got %b expected 0", bus.hazard_stall); end
        step();
        idle();
    endtask

    task automatic test_reset_mid();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd3;
        step();
        bus.issue_valid = 1'b0;
        bus.lu_valid    = 1'b1;
        bus.lu_rd       = 5'd3;
        bus.lu_data     = 32'h0000_0033;
        bus.pipe_valid  = 1'b1;
        bus.pipe_rd     = 5'd4;
        bus.pipe_data   = 32'h0000_0044;
        exp_q.push_back('{cyc, 5'd4, 32'h0000_0044});
        step();
        bus.lu_valid  = 1'b0;
        bus.pipe_rd   = 5'd6;
        bus.pipe_data = 32'h0000_0066;
        exp_q.push_back('{cyc, 5'd6, 32'h0000_0066});
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.lu_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_held: got lu_ready %b expected 0", bus.lu_ready); end
        step();
        rst_n = 1'b1;
        idle();
        bus.issue_rd = 5'd3;
        bus.dec_rs1  = 5'd3;
        @(negedge clk);
        n_checks++;
        if (bus.lu_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_lu_ready: got %b expected 1", bus.lu_ready); end
        n_checks++;
        if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_issue_ready: got %b expected 1", bus.issue_ready); end
        n_checks++;
        if (bus.hazard_stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_hazard: got %b expected 0", bus.hazard_stall); end
        n_checks++;
        if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_rf_we: got %b expected 0", bus.rf_we); end
        step();
        @(negedge clk);
        n_checks++;
        if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_rf_we_later: got %b expected 0", bus.rf_we); end
        step();
        idle();
    endtask

    initial begin
        test_reset();
        test_issue_drain();
        test_starvation();
        test_issue_blocked();
        test_zero_rd();
        test_back_to_back();
        test_reset_mid();
        step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL writes_outstanding: got %0d pending expected writes, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_scheduler.md
# wb_scheduler

Arbitrates the single register-file write port between the in-order pipeline writeback result and a long-latency unit (multiply/divide, late load), and tracks outstanding long-latency destinations. Sits between the writeback stage and the register file. Drives decode-stage hazard stalls through a per-register pending scoreboard. Holds one long-latency result in a buffer until a write slot is granted, with bounded starvation.

## Interface
- XLEN, 32, data width
- NREG, 32, architectural registers; register address width is log2(NREG)
- STARVE_MAX, 4, consecutive lost arbitrations before the buffer forces a slot (≥1)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- issue_valid  in  1  long-latency op issued this cycle
- issue_rd  in  5  its destination
- issue_ready  out  1  issue accepted; = !pending[issue_rd] (combinational, pre-update state)
- dec_rs1, dec_rs2, dec_rd  in  5 each  decode-stage operands/destination
- hazard_stall  out  1  any of dec_rs1/rs2/rd pending (x0 never pending)
- pipe_valid  in  1  pipeline writeback wants to write
- pipe_rd  in  5, pipe_data  in  XLEN  pipeline result (output of writeback mux)
- pipe_stall  out  1  pipeline writeback must hold its result this cycle
- lu_valid  in  1, lu_rd  in  5, lu_data  in  XLEN  long-latency result
- lu_ready  out  1  = !buf_valid
- rf_we  out  1, rf_rd  out  5, rf_data  out  XLEN  register-file write port (combinational from grant)

## Operation
- Scoreboard: NREG-bit pending vector.
  - Set pending[issue_rd] when issue_valid && issue_ready && issue_rd≠0.
  - Cleared when the buffered result is granted the port.
  - Set and clear of the same register in one cycle cannot occur: issue_ready uses pre-clear state.
- Buffer: one entry {rd, data}. Loaded on lu_valid && lu_ready. Buffer-state values:
  - EMPTY: buf_valid=0.
  - HELD: buf_valid=1, starve_cnt<STARVE_MAX.
  - FORCE: buf_valid=1, starve_cnt==STARVE_MAX.
- Arbitration each cycle:
  - pipe_valid && pipe_rd==0: accepted and dropped. No port use, pipe_stall=0, buffer may drain the same cycle.
  - EMPTY: pipe writes if pipe_valid.
  - HELD, pipe requests (rd≠0): pipe granted, starve_cnt+1.
  - HELD, pipe idle: buffer granted, buffer goes to EMPTY.
  - FORCE: buffer granted. pipe_stall=pipe_valid&&pipe_rd≠0. Buffer goes to EMPTY.
  - Buffer drain → starve_cnt=0.
- Buffered rd==0 (defensive): drains without rf_we and without a scoreboard change.
- rf_rd/rf_data come from the granted source. They are don't-care when rf_we=0.
- No WAW case arises: hazard_stall on dec_rd keeps the pipeline from writing a pending register.

## Timing
- Reset (rst_n=0 at edge): pending=0, buf_valid=0, starve_cnt=0. Outputs after reset: rf_we=0, pipe_stall=0, hazard_stall=0, lu_ready=1, issue_ready=1.
- Reset mid-operation discards the buffered result and all pending bits.
- lu result to rf_we: minimum 1 cycle (captured at edge N, written in cycle N+1 if uncontested).
- Worst case, with the pipeline writing every cycle: written STARVE_MAX+1 cycles after capture.
- Pipeline result: written in the same cycle as pipe_valid unless pipe_stall.
- lu_ready is low during the drain cycle. A new result is accepted no earlier than the cycle after drain (one bubble, by design).
- hazard_stall drops in the cycle after drain: the pending bit clears at the drain edge.
- pipe_stall and hazard_stall are combinational from current state and inputs.

## Structure
- Shared package jarvis_pkg: REG_ADDR_W, grant enum {GNT_NONE, GNT_PIPE, GNT_BUF}, buffer-state enum {EMPTY, HELD, FORCE}.
- Sub-module scoreboard: pending vector, set/clear ports, three combinational lookups plus the issue lookup.
- Top level holds the buffer, starve counter and grant logic.

## Test plan
- Issue rd=5, then lu result rd=5 data=0xDEADBEEF, pipe idle → rf_we=1, rf_rd=5 one cycle after capture. pending[5] clears. hazard_stall for dec_rs1=5 drops next cycle.
- Buffer HELD with pipe_valid every cycle (rd=1..) and STARVE_MAX=4 → four pipe grants, then buffer granted and pipe_stall=1 for exactly one cycle.
- Issue rd=7 while pending[7] → issue_ready=0, no state change. Issue rd=0 → issue_ready=1, no pending bit set.
- pipe_valid with pipe_rd=0 while HELD → rf_we=1 for the buffer, pipe_stall=0, starve_cnt reset.
- lu_valid on the drain cycle → lu_ready=0, not accepted. Accepted the next cycle.
- rst_n=0 while HELD with pending[3]=1 → after the edge buf_valid=0, pending=0, lu_ready=1, no rf_we.
